// File: rtl/adc_sample_sequencer.sv
// Periodic MCP3202 conversion sequencer with a first-word-fall-through sample FIFO.
// Define ADC_SEQ_AVG4_EN to push one truncated average per four captures instead of every raw capture.
module adc_sample_sequencer #(
  parameter int SAMPLE_DIV = 1000,
  parameter int TIMEOUT    = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear_flags,
  input  logic        conv_busy,
  input  logic [11:0] conv_data,
  output logic        start_read,
  output logic [11:0] sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overflow,
  output logic        missed_tick,
  output logic        timeout_err
);

  localparam int DivW = $clog2(SAMPLE_DIV);
  localparam int ToW  = $clog2(TIMEOUT) + 1;
  localparam int PtrW = $clog2(FIFO_DEPTH);
  localparam int CntW = PtrW + 1;

  typedef enum logic [2:0] {IDLE, WAIT_TICK, REQUEST, WAIT_BUSY, WAIT_DONE, CAPTURE} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_cnt_q;
  logic              tick_q;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic              start_q, start_d;
  logic              capture, timeout_set, missed_set;
  logic              push, pop, push_ok, full, overflow_set;
  logic [11:0]       push_data;
  logic [11:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              overflow_q, missed_q, timeout_q;

  // Tick is registered so the first request lands SAMPLE_DIV+1 cycles after enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else if (!enable) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      tick_q    <= (div_cnt_q == DivW'(SAMPLE_DIV - 1));
      div_cnt_q <= (div_cnt_q == DivW'(SAMPLE_DIV - 1)) ? '0 : div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      to_cnt_q <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      start_q  <= start_d;
    end
  end

  // The REQUEST cycle counts as timeout cycle 0, so the error lands TIMEOUT cycles after start_read.
  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    capture     = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      IDLE:      if (enable) state_d = WAIT_TICK;
      WAIT_TICK: begin
        if (!enable)     state_d = IDLE;
        else if (tick_q) state_d = REQUEST;
      end
      REQUEST: begin
        state_d  = WAIT_BUSY;
        to_cnt_d = ToW'(1);
      end
      WAIT_BUSY: begin
        if (conv_busy) begin
          state_d = WAIT_DONE;
        end else if (to_cnt_q == ToW'(TIMEOUT - 1)) begin
          timeout_set = 1'b1;
          state_d     = WAIT_TICK;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      WAIT_DONE: if (!conv_busy) state_d = CAPTURE;
      CAPTURE: begin
        capture = 1'b1;
        state_d = enable ? WAIT_TICK : IDLE;
      end
      default:   state_d = IDLE;
    endcase
    start_d    = (state_d == REQUEST);
    missed_set = tick_q && (state_q != WAIT_TICK);
  end

`ifdef ADC_SEQ_AVG4_EN
  logic [13:0] acc_q, acc_d, sum;
  logic [1:0]  phase_q, phase_d;

  // Only the fourth capture of a group reaches the FIFO; timeouts never capture, so they leave the phase alone.
  always_comb begin
    sum       = acc_q + {2'b00, conv_data};
    acc_d     = acc_q;
    phase_d   = phase_q;
    push      = 1'b0;
    push_data = sum[13:2];
    if (state_q == IDLE) begin
      acc_d   = '0;
      phase_d = '0;
    end else if (capture) begin
      if (phase_q == 2'd3) begin
        push    = 1'b1;
        acc_d   = '0;
        phase_d = '0;
      end else begin
        acc_d   = sum;
        phase_d = phase_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      phase_q <= '0;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
    end
  end
`else
  assign push      = capture;
  assign push_data = conv_data;
`endif

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted then.
  assign full         = (count_q == CntW'(FIFO_DEPTH));
  assign pop          = sample_ready && (count_q != '0);
  assign push_ok      = push && (!full || pop);
  assign overflow_set = push && full && !pop;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Sticky flags: a set event in the same cycle as clear_flags wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      missed_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      overflow_q <= overflow_set | (overflow_q & ~clear_flags);
      missed_q   <= missed_set   | (missed_q   & ~clear_flags);
      timeout_q  <= timeout_set  | (timeout_q  & ~clear_flags);
    end
  end

  assign start_read   = start_q;
  assign sample_data  = mem_q[rd_ptr_q];
  assign sample_valid = (count_q != '0);
  assign overflow     = overflow_q;
  assign missed_tick  = missed_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Self-checking bench for adc_sample_sequencer: an SPI-reader responder model feeds a scoreboard
// queue of expected samples that is compared whenever the consumer pops the FIFO head.
module tb_adc_sample_sequencer;

  localparam int SampleDiv = 16;
  localparam int Timeout   = 64;
  localparam int FifoDepth = 4;

  logic        clk = 1'b0;
  logic        reset, enable, clearFlags, convBusy, sampleReady;
  logic [11:0] convData;
  logic        start_read, sample_valid, overflow, missed_tick, timeout_err;
  logic [11:0] sample_data;

  int errors = 0;
  int checks = 0;
  int cycleCount = 0;

  int          modelBusyLen = 8;
  bit          modelNeverBusy = 1'b0;
  bit          autoExpect = 1'b1;
  logic [11:0] modelData = 12'hA5C;
  logic [11:0] dataQ[$];
  logic [11:0] expQ[$];
  int          busyLeft = 0;
  int          dropCount = 0;
  int          popCount = 0;
  logic [11:0] monitorExp;
  logic [11:0] nextData;

  adc_sample_sequencer #(
    .SAMPLE_DIV(SampleDiv), .TIMEOUT(Timeout), .FIFO_DEPTH(FifoDepth)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear_flags(clearFlags),
    .conv_busy(convBusy), .conv_data(convData), .start_read(start_read),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sampleReady),
    .overflow(overflow), .missed_tick(missed_tick), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // SPI reader stand-in: busy rises on the start_read cycle, data appears as busy falls.
  always @(negedge clk) begin
    if (reset) begin
      convBusy = 1'b0;
      busyLeft = 0;
    end else begin
      if (busyLeft > 0) begin
        busyLeft--;
        if (busyLeft == 0) begin
          nextData = (dataQ.size() > 0) ? dataQ.pop_front() : modelData;
          convData = nextData;
          convBusy = 1'b0;
          dropCount++;
          if (autoExpect && expQ.size() < FifoDepth) expQ.push_back(nextData);
        end
      end
      if (start_read === 1'b1 && !modelNeverBusy) begin
        convBusy = 1'b1;
        busyLeft = modelBusyLen;
      end
    end
  end

  // Consumer side of the scoreboard: every accepted pop must match the oldest expected sample.
  always @(negedge clk) begin
    #2;
    if (reset === 1'b0 && sample_valid === 1'b1 && sampleReady === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL pop_unexpected: got data=%h, no sample expected", sample_data);
      end else begin
        monitorExp = expQ.pop_front();
        if (sample_data !== monitorExp) begin
          errors++;
          $display("[TB] FAIL pop_data: got %h expected %h", sample_data, monitorExp);
        end
      end
      popCount++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog");
  end

  task automatic nextCycle;
    @(negedge clk);
    #1;
  endtask

  task automatic waitStart(input int budget, output int atCycle);
    atCycle = -1;
    for (int i = 0; i < budget; i++) begin
      nextCycle();
      if (start_read === 1'b1) begin
        atCycle = cycleCount;
        break;
      end
    end
  endtask

  task automatic waitDrops(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dropCount >= target) begin
        ok = 1'b1;
        break;
      end
      nextCycle();
    end
  endtask

  task automatic applyReset;
    reset = 1'b1; enable = 1'b0; clearFlags = 1'b0; sampleReady = 1'b0;
    modelNeverBusy = 1'b0; modelBusyLen = 8; autoExpect = 1'b1; modelData = 12'hA5C;
    repeat (2) nextCycle();
    expQ.delete();
    dataQ.delete();
    dropCount = 0;
    reset = 1'b0;
    nextCycle();
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; clearFlags = 1'b0; sampleReady = 1'b0; convData = '0;
    repeat (2) nextCycle();
    checks++; if (start_read !== 1'b0) begin errors++; $display("[TB] FAIL reset_start_read: got %b expected 0", start_read); end
    checks++; if (sample_data !== 12'h000) begin errors++; $display("[TB] FAIL reset_sample_data: got %h expected 000", sample_data); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_sample_valid: got %b expected 0", sample_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (missed_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_missed_tick: got %b expected 0", missed_tick); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    reset = 1'b0;
    repeat (20) nextCycle();
    checks++; if (start_read !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_request: got %b expected 0", start_read); end
  endtask

  task automatic test_periodic;
    int enCyc, s1, s2, s3, p0;
    applyReset();
    sampleReady = 1'b1;
    p0 = popCount;
    enable = 1'b1;
    enCyc = cycleCount;
    waitStart(100, s1);
    checks++; if (s1 - enCyc != SampleDiv + 1) begin errors++; $display("[TB] FAIL first_request_latency: got %0d expected %0d", s1 - enCyc, SampleDiv + 1); end
    repeat (9) nextCycle();
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("[TB] FAIL valid_too_early: got %b expected 0", sample_valid); end
    nextCycle();
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("[TB] FAIL valid_latency: got %b expected 1", sample_valid); end
    checks++; if (sample_data !== 12'hA5C) begin errors++; $display("[TB] FAIL head_data: got %h expected a5c", sample_data); end
    waitStart(100, s2);
    checks++; if (s2 - s1 != SampleDiv) begin errors++; $display("[TB] FAIL request_spacing_1: got %0d expected %0d", s2 - s1, SampleDiv); end
    waitStart(100, s3);
    checks++; if (s3 - s2 != SampleDiv) begin errors++; $display("[TB] FAIL request_spacing_2: got %0d expected %0d", s3 - s2, SampleDiv); end
    enable = 1'b0;
    repeat (30) nextCycle();
    checks++; if (popCount - p0 != 3) begin errors++; $display("[TB] FAIL periodic_pop_count: got %0d expected 3", popCount - p0); end
  endtask

  task automatic test_overflow;
    bit ok;
    int p0;
    applyReset();
    dataQ = '{12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6};
    enable = 1'b1;
    waitDrops(4, 200, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL ovf_wait4: got drops=%0d expected 4", dropCount); end
    repeat (3) nextCycle();
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_after_four: got %b expected 0", overflow); end
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovf_valid_full: got %b expected 1", sample_valid); end
    waitDrops(5, 200, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL ovf_wait5: got drops=%0d expected 5", dropCount); end
    nextCycle();
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early: got %b expected 0", overflow); end
    nextCycle();
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_after_fifth: got %b expected 1", overflow); end
    waitDrops(6, 200, ok);
    enable = 1'b0;
    repeat (20) nextCycle();
    p0 = popCount;
    sampleReady = 1'b1;
    repeat (8) nextCycle();
    checks++; if (popCount - p0 != FifoDepth) begin errors++; $display("[TB] FAIL ovf_pop_count: got %0d expected %0d", popCount - p0, FifoDepth); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drained: got %b expected 0", sample_valid); end
    clearFlags = 1'b1;
    nextCycle();
    clearFlags = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_timeout;
    int s1, s2, waited;
    applyReset();
    modelNeverBusy = 1'b1;
    enable = 1'b1;
    waitStart(100, s1);
    waited = -1;
    for (int i = 1; i <= 100; i++) begin
      nextCycle();
      if (timeout_err === 1'b1) begin
        waited = i;
        break;
      end
    end
    checks++; if (waited != Timeout) begin errors++; $display("[TB] FAIL timeout_latency: got %0d expected %0d", waited, Timeout); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("[TB] FAIL timeout_no_push: got %b expected 0", sample_valid); end
    waitStart(100, s2);
    checks++; if (s2 - s1 != 5 * SampleDiv) begin errors++; $display("[TB] FAIL timeout_next_request: got %0d expected %0d", s2 - s1, 5 * SampleDiv); end
    enable = 1'b0;
    modelNeverBusy = 1'b0;
  endtask

  task automatic test_missed_tick;
    int s1, p0;
    applyReset();
    modelBusyLen = 40;
    sampleReady = 1'b1;
    p0 = popCount;
    enable = 1'b1;
    waitStart(100, s1);
    repeat (15) nextCycle();
    checks++; if (missed_tick !== 1'b0) begin errors++; $display("[TB] FAIL missed_early: got %b expected 0", missed_tick); end
    nextCycle();
    checks++; if (missed_tick !== 1'b1) begin errors++; $display("[TB] FAIL missed_set: got %b expected 1", missed_tick); end
    repeat (4) nextCycle();
    clearFlags = 1'b1;
    nextCycle();
    clearFlags = 1'b0;
    checks++; if (missed_tick !== 1'b0) begin errors++; $display("[TB] FAIL missed_clear: got %b expected 0", missed_tick); end
    repeat (10) nextCycle();
    clearFlags = 1'b1;
    nextCycle();
    clearFlags = 1'b0;
    checks++; if (missed_tick !== 1'b1) begin errors++; $display("[TB] FAIL missed_set_beats_clear: got %b expected 1", missed_tick); end
    enable = 1'b0;
    repeat (30) nextCycle();
    checks++; if (popCount - p0 != 1) begin errors++; $display("[TB] FAIL missed_long_capture: got %0d pops expected 1", popCount - p0); end
  endtask

  task automatic test_enable_drop;
    int s1, p0, pulses;
    applyReset();
    sampleReady = 1'b1;
    p0 = popCount;
    enable = 1'b1;
    waitStart(100, s1);
    repeat (4) nextCycle();
    enable = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      nextCycle();
      if (start_read === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL drop_no_request: got %0d pulses expected 0", pulses); end
    checks++; if (popCount - p0 != 1) begin errors++; $display("[TB] FAIL drop_sample_pushed: got %0d pops expected 1", popCount - p0); end
    sampleReady = 1'b0;
    enable = 1'b1;
    waitStart(100, s1);
    waitStart(100, s1);
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_valid: got %b expected 1", sample_valid); end
    reset = 1'b1;
    #1;
    checks++; if (start_read !== 1'b0) begin errors++; $display("[TB] FAIL midreset_start_read: got %b expected 0", start_read); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_sample_valid: got %b expected 0", sample_valid); end
    checks++; if (sample_data !== 12'h000) begin errors++; $display("[TB] FAIL midreset_sample_data: got %h expected 000", sample_data); end
    enable = 1'b0;
    nextCycle();
    expQ.delete();
    reset = 1'b0;
    nextCycle();
  endtask

  task automatic test_averaging;
    bit ok;
    int p0, expPops, expAfterThree;
    applyReset();
    autoExpect = 1'b0;
    sampleReady = 1'b1;
    dataQ = '{12'd100, 12'd101, 12'd102, 12'd105};
`ifdef ADC_SEQ_AVG4_EN
    expQ.push_back(12'd102);
    expPops = 1;
    expAfterThree = 0;
`else
    expQ.push_back(12'd100); expQ.push_back(12'd101); expQ.push_back(12'd102); expQ.push_back(12'd105);
    expPops = 4;
    expAfterThree = 3;
`endif
    p0 = popCount;
    enable = 1'b1;
    waitDrops(3, 200, ok);
    repeat (4) nextCycle();
    checks++; if (popCount - p0 != expAfterThree) begin errors++; $display("[TB] FAIL avg_after_three: got %0d pops expected %0d", popCount - p0, expAfterThree); end
    waitDrops(4, 200, ok);
    enable = 1'b0;
    repeat (10) nextCycle();
    checks++; if (popCount - p0 != expPops) begin errors++; $display("[TB] FAIL avg_pop_count: got %0d pops expected %0d", popCount - p0, expPops); end
    checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL avg_outstanding: got %0d unpopped expected 0", expQ.size()); end
    autoExpect = 1'b1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clearFlags = 1'b0; sampleReady = 1'b0;
    convBusy = 1'b0; convData = '0;
    test_reset();
    test_periodic();
    test_overflow();
    test_timeout();
    test_missed_tick();
    test_enable_drop();
    test_averaging();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
